// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - fetch/load-store arbiter onto one single-port synchronous memory.
// Optional stall counters are enabled with `define ARB_PERF_CNT_EN.
module imem_dmem_arbiter #(
    parameter int ADDR_WIDTH    = 12,
    parameter int DATA_WIDTH    = 32,
    parameter int DATA_PRIORITY = 1,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_valid,
    input  logic [ADDR_WIDTH-1:0]   if_req_addr,
    output logic                    if_req_ready,
    output logic                    if_resp_valid,
    output logic [DATA_WIDTH-1:0]   if_resp_data,
    input  logic                    d_req_valid,
    input  logic [ADDR_WIDTH-1:0]   d_req_addr,
    input  logic [DATA_WIDTH/8-1:0] d_req_we,
    input  logic [DATA_WIDTH-1:0]   d_req_wdata,
    output logic                    d_req_ready,
    output logic                    d_resp_valid,
    output logic [DATA_WIDTH-1:0]   d_resp_data,
    output logic                    mem_en,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_din,
    input  logic [DATA_WIDTH-1:0]   mem_dout
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]             perf_if_stall,
    output logic [31:0]             perf_d_stall
`endif
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_RD_PEND = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_owner_d;
    logic [3:0]            r_starve_cnt;
    logic                  r_last_d_won;
    logic [DATA_WIDTH-1:0] r_if_data_hold;
    logic [DATA_WIDTH-1:0] r_d_data_hold;

    logic w_conflict;
    logic w_if_wins_conf;
    logic w_grant_if;
    logic w_grant_d;
    logic w_rd_grant;

    // Fetch wins a conflict when starved (priority mode) or when data won the last one (round-robin).
    assign w_conflict     = if_req_valid && d_req_valid;
    assign w_if_wins_conf = (DATA_PRIORITY != 0) ? (r_starve_cnt == STARVE_MAX) : r_last_d_won;
    assign w_grant_if     = rst && if_req_valid && (!d_req_valid || w_if_wins_conf);
    assign w_grant_d      = rst && d_req_valid && (!if_req_valid || !w_if_wins_conf);
    assign w_rd_grant     = w_grant_if || (w_grant_d && (d_req_we == '0));

    assign if_req_ready = w_grant_if;
    assign d_req_ready  = w_grant_d;

    always_comb begin
        mem_en   = w_grant_if || w_grant_d;
        mem_we   = '0;
        mem_addr = if_req_addr;
        mem_din  = '0;
        if (w_grant_d) begin
            mem_we   = d_req_we;
            mem_addr = d_req_addr;
            mem_din  = d_req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= 4'd0;
            r_last_d_won <= 1'b0;
        end else begin
            if (!if_req_valid || w_grant_if) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
            if (w_conflict) begin
                r_last_d_won <= w_grant_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_owner_d <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_rd_grant) begin
                r_owner_d <= w_grant_d;
            end
        end
    end

    always_comb begin
        w_next_state = S_IDLE;
        if (w_rd_grant) begin
            w_next_state = S_RD_PEND;
        end
    end

    // Each response port shows mem_dout in its valid cycle and otherwise holds its last word.
    always_comb begin
        if_resp_valid = (r_state == S_RD_PEND) && !r_owner_d;
        d_resp_valid  = (r_state == S_RD_PEND) && r_owner_d;
        if_resp_data  = if_resp_valid ? mem_dout : r_if_data_hold;
        d_resp_data   = d_resp_valid ? mem_dout : r_d_data_hold;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_data_hold <= '0;
            r_d_data_hold  <= '0;
        end else begin
            r_if_data_hold <= if_resp_data;
            r_d_data_hold  <= d_resp_data;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_if_stall;
    logic [31:0] r_perf_d_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_if_stall <= 32'd0;
            r_perf_d_stall  <= 32'd0;
        end else begin
            if (if_req_valid && !if_req_ready) begin
                r_perf_if_stall <= r_perf_if_stall + 32'd1;
            end
            if (d_req_valid && !d_req_ready) begin
                r_perf_d_stall <= r_perf_d_stall + 32'd1;
            end
        end
    end

    assign perf_if_stall = r_perf_if_stall;
    assign perf_d_stall  = r_perf_d_stall;
`endif

endmodule
